// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async_fifo write port among
// NUM_REQ valid/ready requesters. A winner is chosen combinationally, so a
// request can be written in the cycle it arrives. The winner then keeps the
// port for up to BURST_MAX consecutive words before the pointer moves on. No
// write is ever issued while fifo_full is high.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id,
  output logic [15:0]                   wr_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [3:0]     BURST_LIM = 4'(BURST_MAX);

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]     burst_cnt_q, burst_cnt_d;
  logic [15:0]    wr_count_q, wr_count_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] cand;
  logic           cand_valid;
  logic           transfer;
  logic [3:0]     burst_inc;

  // The index after id, wrapping the last requester back to 0 even when
  // NUM_REQ is not a power of two.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Round-robin scan: the first valid requester at or after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
      scan_idx = next_id(scan_idx);
    end
  end

  // Write-port outputs. These are forced to zero while reset is held, so a
  // reset in the middle of a burst drops the port at once.
  always_comb begin
    cand         = (state_q == HOLD) ? owner_q : win_id;
    cand_valid   = (state_q == HOLD) || win_found;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    if (!wr_rst && cand_valid) begin
      grant_valid  = 1'b1;
      grant_id     = cand;
      fifo_data_in = req_data[int'(cand)*DATA_WIDTH +: DATA_WIDTH];
      if (!fifo_full) begin
        req_ready[cand] = 1'b1;
        fifo_wr_en      = req_valid[cand];
      end
    end
  end

  assign transfer = fifo_wr_en;
  assign wr_count = wr_count_q;

  // Next-state logic: take ownership, count burst words, and release the
  // grant on the burst limit or when the owner drops valid.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    burst_inc   = burst_cnt_q + 4'd1;
    wr_count_d  = wr_count_q + {15'd0, transfer};
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (BURST_MAX == 1) begin
            rr_ptr_d = next_id(win_id);
          end else begin
            state_d     = HOLD;
            owner_d     = win_id;
            burst_cnt_d = 4'd1;
          end
        end
      end
      HOLD: begin
        if (!req_valid[owner_q]) begin
          state_d     = IDLE;
          rr_ptr_d    = next_id(owner_q);
          burst_cnt_d = 4'd0;
        end else if (transfer) begin
          if (burst_inc == BURST_LIM) begin
            state_d     = IDLE;
            rr_ptr_d    = next_id(owner_q);
            burst_cnt_d = 4'd0;
          end else begin
            burst_cnt_d = burst_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers, cleared asynchronously by wr_rst.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule
